calc_key_fsm: RTL and testbench



---
 rtl/calc_pkg.sv | 31 +++
 rtl/bin_to_bcd4.sv | 36 +++
 rtl/calc_key_fsm.sv | 158 +++++++++++++++
 tb/tb_calc_key_fsm.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants for the keypad calculator: key codes, FSM state encoding,
// operand/result widths and small key-classification helpers.
package calc_pkg;

  // Key codes delivered by the scan-code-to-key decoder
  localparam logic [3:0] KEY_ADD   = 4'd10;
  localparam logic [3:0] KEY_SUB   = 4'd11;
  localparam logic [3:0] KEY_MUL   = 4'd12;
  localparam logic [3:0] KEY_ENTER = 4'd13;
  localparam logic [3:0] KEY_NONE  = 4'd15;

  // Operand, signed result and display magnitude widths
  localparam int unsigned OpW  = 7;
  localparam int unsigned ResW = 15;
  localparam int unsigned MagW = 14;

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_RES = 2'd2
  } state_e;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL);
  endfunction

endpackage

// File: rtl/bin_to_bcd4.sv
// Combinational double-dabble: 14-bit magnitude to four BCD digits, with
// leading zeros above the most significant nonzero digit replaced by BLANK_CODE.
// The ones digit is never blanked so a zero value still shows "0".
module bin_to_bcd4 #(
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input  logic [13:0] bin_i,
  output logic [15:0] bcd_o
);

  logic [15:0] bcd;
  logic        blank3, blank2, blank1;

  // Shift-and-add-3 conversion, MSB first
  always_comb begin
    bcd = '0;
    for (int i = 13; i >= 0; i--) begin
      for (int d = 0; d < 4; d++) begin
        if (bcd[d*4 +: 4] >= 4'd5) bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      end
      bcd = {bcd[14:0], bin_i[i]};
    end
  end

  // Blank a digit only if it and every digit above it is zero
  always_comb begin
    blank3 = (bcd[15:12] == 4'd0);
    blank2 = blank3 && (bcd[11:8] == 4'd0);
    blank1 = blank2 && (bcd[7:4] == 4'd0);
    bcd_o  = {blank3 ? BLANK_CODE : bcd[15:12],
              blank2 ? BLANK_CODE : bcd[11:8],
              blank1 ? BLANK_CODE : bcd[7:4],
              bcd[3:0]};
  end

endmodule

// File: rtl/calc_key_fsm.sv
// Keypad calculator front end: builds operand A, operator and operand B from
// decoded key presses, computes the signed result on Enter and feeds BCD digits
// plus a sign flag to the seven-segment scanner.
// Optional build macro CALC_CHAIN_EN: an operator pressed while a small
// non-negative result is shown reuses that result as operand A.
module calc_key_fsm
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS     = 2,
  parameter logic [3:0]  BLANK_CODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_in,
  output logic [15:0] disp_bcd,
  output logic        neg,
  output logic [1:0]  state
);

  localparam logic [1:0] DigitsL = 2'(DIGITS);
`ifdef CALC_CHAIN_EN
  localparam logic [ResW-1:0] MaxChain = ResW'(10 ** DIGITS - 1);
`endif

  state_e            state_q, state_d;
  logic [OpW-1:0]    op_a_q, op_a_d;
  logic [OpW-1:0]    op_b_q, op_b_d;
  logic [3:0]        op_q, op_d;
  logic [1:0]        a_cnt_q, a_cnt_d;
  logic [1:0]        b_cnt_q, b_cnt_d;
  logic [ResW-1:0]   res_q, res_d;

  logic [OpW-1:0]    acc_a, acc_b;
  logic [MagW-1:0]   prod;
  logic [ResW-1:0]   calc;
  logic [MagW-1:0]   mag;
  logic [MagW-1:0]   disp_bin;

  // Decimal accumulation and the three arithmetic results
  always_comb begin
    acc_a = op_a_q * 7'd10 + {3'b000, key_in};
    acc_b = op_b_q * 7'd10 + {3'b000, key_in};
    prod  = {7'b0, op_a_q} * {7'b0, op_b_q};
    unique case (op_q)
      KEY_SUB: calc = {8'b0, op_a_q} - {8'b0, op_b_q};
      KEY_MUL: calc = {1'b0, prod};
      default: calc = {8'b0, op_a_q} + {8'b0, op_b_q};
    endcase
  end

  // Key-driven next state; everything holds unless key_valid is set
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    op_d    = op_q;
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    res_d   = res_q;
    case (state_q)
      S_A: begin
        if (key_valid) begin
          if (is_digit(key_in)) begin
            if (a_cnt_q < DigitsL) begin
              op_a_d  = acc_a;
              a_cnt_d = a_cnt_q + 2'd1;
            end
          end else if (is_op(key_in)) begin
            op_d    = key_in;
            state_d = S_B;
          end
        end
      end
      S_B: begin
        if (key_valid) begin
          if (is_digit(key_in)) begin
            if (b_cnt_q < DigitsL) begin
              op_b_d  = acc_b;
              b_cnt_d = b_cnt_q + 2'd1;
            end
          end else if (is_op(key_in)) begin
            // Operator can still be changed until B has a digit
            if (b_cnt_q == 2'd0) op_d = key_in;
          end else if (key_in == KEY_ENTER) begin
            res_d   = calc;
            state_d = S_RES;
          end
        end
      end
      S_RES: begin
        if (key_valid) begin
          if (is_digit(key_in)) begin
            op_a_d  = {3'b000, key_in};
            a_cnt_d = 2'd1;
            op_b_d  = '0;
            b_cnt_d = 2'd0;
            op_d    = 4'd0;
            res_d   = '0;
            state_d = S_A;
          end
`ifdef CALC_CHAIN_EN
          else if (is_op(key_in) && !res_q[ResW-1] && (res_q <= MaxChain)) begin
            op_a_d  = res_q[OpW-1:0];
            a_cnt_d = DigitsL;
            op_b_d  = '0;
            b_cnt_d = 2'd0;
            op_d    = key_in;
            state_d = S_B;
          end
`endif
        end
      end
      default: state_d = S_A;
    endcase
  end

  // State and operand registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_A;
      op_a_q  <= '0;
      op_b_q  <= '0;
      op_q    <= '0;
      a_cnt_q <= '0;
      b_cnt_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      op_q    <= op_d;
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
      res_q   <= res_d;
    end
  end

  // Select the value to display and its sign
  always_comb begin
    mag = res_q[ResW-1] ? (~res_q[MagW-1:0] + 14'd1) : res_q[MagW-1:0];
    case (state_q)
      S_B:     disp_bin = {7'b0, op_b_q};
      S_RES:   disp_bin = mag;
      default: disp_bin = {7'b0, op_a_q};
    endcase
    neg   = (state_q == S_RES) && res_q[ResW-1];
    state = state_q;
  end

  bin_to_bcd4 #(
    .BLANK_CODE(BLANK_CODE)
  ) u_bcd (
    .bin_i(disp_bin),
    .bcd_o(disp_bcd)
  );

endmodule

// File: tb/tb_calc_key_fsm.sv
// Self-checking bench for calc_key_fsm: directed scenarios plus randomized key
// streams compared against an integer-level model of the calculator.
module tb_calc_key_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_in = 4'd15;
  logic [15:0] disp_bcd;
  logic        neg;
  logic [1:0]  state;

  int vectors = 0;
  int miscompares = 0;

  // Model: phase 0 entering A, 1 entering B, 2 showing result
  int m_a, m_b, m_op, m_ca, m_cb, m_ph, m_res;

  always #5 clk = ~clk;

  calc_key_fsm #(
    .DIGITS(2),
    .BLANK_CODE(4'hF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_valid(key_valid),
    .key_in(key_in),
    .disp_bcd(disp_bcd),
    .neg(neg),
    .state(state)
  );

  task automatic model_clear();
    m_a = 0; m_b = 0; m_op = 0; m_ca = 0; m_cb = 0; m_ph = 0; m_res = 0;
  endtask

  task automatic model_key(input int k);
    if (k >= 14) return;
    if (m_ph == 0) begin
      if (k <= 9) begin
        if (m_ca < 2) begin m_a = m_a * 10 + k; m_ca++; end
      end else if (k <= 12) begin
        m_op = k; m_ph = 1;
      end
    end else if (m_ph == 1) begin
      if (k <= 9) begin
        if (m_cb < 2) begin m_b = m_b * 10 + k; m_cb++; end
      end else if (k <= 12) begin
        if (m_cb == 0) m_op = k;
      end else begin
        if (m_op == 11) m_res = m_a - m_b;
        else if (m_op == 12) m_res = m_a * m_b;
        else m_res = m_a + m_b;
        m_ph = 2;
      end
    end else begin
      if (k <= 9) begin
        model_clear();
        m_a = k; m_ca = 1;
      end
`ifdef CALC_CHAIN_EN
      else if (k <= 12 && m_res >= 0 && m_res <= 99) begin
        m_a = m_res; m_ca = 2; m_op = k; m_b = 0; m_cb = 0; m_ph = 1;
      end
`endif
    end
  endtask

  function automatic logic [15:0] exp_disp();
    int v;
    logic [3:0] d [4];
    logic blank;
    v = (m_ph == 0) ? m_a : (m_ph == 1) ? m_b : ((m_res < 0) ? -m_res : m_res);
    for (int i = 0; i < 4; i++) begin
      d[i] = 4'(v % 10);
      v = v / 10;
    end
    blank = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (blank && d[i] == 4'd0) d[i] = 4'hF;
      else blank = 1'b0;
    end
    return {d[3], d[2], d[1], d[0]};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    key_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic press(input int k);
    @(negedge clk);
    key_in = 4'(k);
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    key_in = 4'($urandom_range(0, 15));
    model_key(k);
  endtask

  task automatic test_reset();
    do_reset();
    repeat (10) begin
      @(negedge clk);
      key_in = 4'($urandom_range(0, 15));
    end
    vectors++;
    if (disp_bcd !== 16'hFFF0) begin
      $display("FAIL reset_disp: disp_bcd=%h expected FFF0", disp_bcd); miscompares++;
    end
    vectors++;
    if (neg !== 1'b0) begin
      $display("FAIL reset_neg: neg=%b expected 0", neg); miscompares++;
    end
    vectors++;
    if (state !== 2'd0) begin
      $display("FAIL reset_state: state=%0d expected 0", state); miscompares++;
    end
  endtask

  task automatic test_add();
    press(13);
    vectors++;
    if (disp_bcd !== 16'hFFF0 || state !== 2'd0) begin
      $display("FAIL enter_in_a: disp=%h state=%0d expected FFF0 0", disp_bcd, state);
      miscompares++;
    end
    press(1);
    press(2);
    vectors++;
    if (disp_bcd !== 16'hFF12) begin
      $display("FAIL add_opa: disp_bcd=%h expected FF12", disp_bcd); miscompares++;
    end
    press(10);
    press(3);
    press(4);
    vectors++;
    if (disp_bcd !== 16'hFF34 || state !== 2'd1) begin
      $display("FAIL add_opb: disp=%h state=%0d expected FF34 1", disp_bcd, state);
      miscompares++;
    end
    press(13);
    vectors++;
    if (disp_bcd !== 16'hFF46 || neg !== 1'b0 || state !== 2'd2) begin
      $display("FAIL add_result: disp=%h neg=%b state=%0d expected FF46 0 2",
               disp_bcd, neg, state);
      miscompares++;
    end
  endtask

  task automatic test_res_operator();
    press(13);
    vectors++;
    if (disp_bcd !== 16'hFF46 || state !== 2'd2) begin
      $display("FAIL res_enter: disp=%h state=%0d expected FF46 2", disp_bcd, state);
      miscompares++;
    end
`ifdef CALC_CHAIN_EN
    press(10);
    press(4);
    press(13);
    vectors++;
    if (disp_bcd !== 16'hFF50 || state !== 2'd2) begin
      $display("FAIL chain_result: disp=%h state=%0d expected FF50 2", disp_bcd, state);
      miscompares++;
    end
`else
    press(10);
    vectors++;
    if (disp_bcd !== 16'hFF46 || state !== 2'd2) begin
      $display("FAIL res_op_ignored: disp=%h state=%0d expected FF46 2", disp_bcd, state);
      miscompares++;
    end
`endif
  endtask

  task automatic test_sub();
    press(5);
    press(11);
    press(1);
    press(2);
    press(13);
    vectors++;
    if (disp_bcd !== 16'hFFF7 || neg !== 1'b1) begin
      $display("FAIL sub_negative: disp=%h neg=%b expected FFF7 1", disp_bcd, neg);
      miscompares++;
    end
  endtask

  task automatic test_mul();
    press(9); press(9); press(12); press(9); press(9); press(13);
    vectors++;
    if (disp_bcd !== 16'h9801 || neg !== 1'b0) begin
      $display("FAIL mul_max: disp=%h neg=%b expected 9801 0", disp_bcd, neg);
      miscompares++;
    end
  endtask

  task automatic test_saturate_and_op_replace();
    press(1); press(2); press(3); press(15); press(7); press(15);
    vectors++;
    if (disp_bcd !== 16'hFF12) begin
      $display("FAIL digit_saturate: disp_bcd=%h expected FF12", disp_bcd); miscompares++;
    end
    press(10);
    press(11);
    press(2);
    press(13);
    vectors++;
    if (disp_bcd !== 16'hFF10 || neg !== 1'b0) begin
      $display("FAIL op_replace: disp=%h neg=%b expected FF10 0", disp_bcd, neg);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    press(1); press(10); press(3);
    vectors++;
    if (disp_bcd !== 16'hFFF3 || state !== 2'd1) begin
      $display("FAIL pre_reset_b: disp=%h state=%0d expected FFF3 1", disp_bcd, state);
      miscompares++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (state !== 2'd0 || disp_bcd !== 16'hFFF0) begin
      $display("FAIL async_reset: disp=%h state=%0d expected FFF0 0", disp_bcd, state);
      miscompares++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    press(4);
    vectors++;
    if (disp_bcd !== 16'hFFF4 || state !== 2'd0) begin
      $display("FAIL after_reset_key: disp=%h state=%0d expected FFF4 0", disp_bcd, state);
      miscompares++;
    end
  endtask

  task automatic test_random();
    int k;
    logic [15:0] ed;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          key_in = 4'($urandom_range(0, 15));
        end
      end
      // Bias toward digits and Enter so results are reached often
      case ($urandom_range(0, 3))
        0, 1:    k = int'($urandom_range(0, 9));
        2:       k = int'($urandom_range(10, 13));
        default: k = int'($urandom_range(0, 15));
      endcase
      press(k);
      ed = exp_disp();
      vectors++;
      if (disp_bcd !== ed || neg !== (m_ph == 2 && m_res < 0) || state !== 2'(m_ph)) begin
        $display("FAIL random_key%0d k=%0d: disp=%h neg=%b state=%0d expected %h %b %0d",
                 n, k, disp_bcd, neg, state, ed, (m_ph == 2 && m_res < 0), m_ph);
        miscompares++;
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_add();
    test_res_operator();
    do_reset();
    test_add();
    test_sub();
    test_mul();
    test_saturate_and_op_replace();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
